// File: rtl/mux4_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_arbiter
//
// Round-robin arbiter that shares one 4-input data mux between four
// requesters. Exactly one requester is granted at a time. Each tenure is
// bounded by MAX_HOLD cycles whenever someone else is waiting. Every tenure
// is followed by one dead TURN cycle, so two grants never overlap.
//
// Parameters
//   DATA_WIDTH  : width of each data input and of data_o
//   SELECT_SIZE : width of select_o (2 for four requesters)
//   MAX_HOLD    : maximum consecutive granted cycles per tenure (1..255)
//
// Ports
//   clk_i     in   clock, rising edge active
//   reset_i   in   asynchronous, active-high reset
//   req_i     in   request line per requester (bit n = requester n)
//   dataN_i   in   data word of requester N
//   grant_o   out  one-hot grant, all zero when nobody is granted (registered)
//   select_o  out  index of the current or last granted requester (registered)
//   valid_o   out  high while a grant is active (registered)
//   data_o    out  granted requester's data, zero when valid_o is low
//                  (combinational from the registered select/valid)
// -----------------------------------------------------------------------------
module mux4_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int SELECT_SIZE = 2,
  parameter int MAX_HOLD    = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [3:0]             req_i,
  input  logic [DATA_WIDTH-1:0]  data0_i,
  input  logic [DATA_WIDTH-1:0]  data1_i,
  input  logic [DATA_WIDTH-1:0]  data2_i,
  input  logic [DATA_WIDTH-1:0]  data3_i,
  output logic [3:0]             grant_o,
  output logic [SELECT_SIZE-1:0] select_o,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  data_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Last value the hold counter may reach inside one tenure.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e                 state_q, state_d;
  logic [3:0]             grant_q, grant_d;
  logic [SELECT_SIZE-1:0] select_q, select_d;
  logic                   valid_q, valid_d;
  logic [SELECT_SIZE-1:0] ptr_q, ptr_d;
  logic [7:0]             cnt_q, cnt_d;

  // Round-robin search results.
  logic [SELECT_SIZE-1:0] cand;
  logic [SELECT_SIZE-1:0] winner;
  logic                   found;

  // Someone other than the current owner is waiting. grant_q is one-hot on
  // the owner during GRANT, so masking it out leaves only the competitors.
  logic                   others_pending;
  logic                   hold_full;

  assign others_pending = |(req_i & ~grant_q);
  assign hold_full      = (cnt_q == HOLD_LAST);

  // First set request bit searching ptr, ptr+1, ... with 2-bit wrap.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; a path that skips an assignment would otherwise infer a latch.
    found  = 1'b0;
    winner = ptr_q;
    cand   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + SELECT_SIZE'(i);
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    select_d = select_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_GRANT;
          select_d = winner;
          grant_d  = 4'b0001 << winner;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end
      end

      ST_GRANT: begin
        if (!req_i[select_q] || (hold_full && others_pending)) begin
          // Release: the pointer moves past the owner so it goes last next
          // round; select keeps pointing at the previous owner.
          state_d = ST_TURN;
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = select_q + SELECT_SIZE'(1);
          cnt_d   = '0;
        end else if (!hold_full) begin
          cnt_d = cnt_q + 8'd1;
        end
        // Otherwise nobody else is waiting: keep the grant, cnt saturated.
      end

      ST_TURN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      grant_q  <= grant_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Shared data mux, forced to zero while nobody is granted.
  always_comb begin
    data_o = '0;
    if (valid_q) begin
      unique case (select_q)
        2'd0:    data_o = data0_i;
        2'd1:    data_o = data1_i;
        2'd2:    data_o = data2_i;
        default: data_o = data3_i;
      endcase
    end
  end

  assign grant_o  = grant_q;
  assign select_o = select_q;
  assign valid_o  = valid_q;

endmodule

// File: doc/mux4_arbiter.md
Name: mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4-input data mux between four requesters.
- Samples per-requester request lines, grants one at a time, and drives the mux select.
- Forwards the granted requester's data word with a valid flag.
- Bounds each tenure with a hold limit so that no requester starves the others.
- Sits in front of any Mux4-style shared-bus point in the processor datapath, e.g. a shared memory or register-write port.

Parameters:
DATA_WIDTH, 16, width of each data input and of data_o
SELECT_SIZE, 2, width of select_o; fixed at 2 for 4 requesters
MAX_HOLD, 8, maximum consecutive granted cycles per tenure; legal range 1..255

Ports:
clk_i  input  1  system clock, rising-edge active
reset_i  input  1  asynchronous, active-high reset
req_i  input  4  request line per requester; bit n = requester n
data0_i  input  DATA_WIDTH  requester 0 data
data1_i  input  DATA_WIDTH  requester 1 data
data2_i  input  DATA_WIDTH  requester 2 data
data3_i  input  DATA_WIDTH  requester 3 data
grant_o  output  4  one-hot grant; all zero when no grant
select_o  output  SELECT_SIZE  index of the current or last granted requester
valid_o  output  1  high while a grant is active
data_o  output  DATA_WIDTH  data of the granted requester; zero when valid_o=0

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, grant_o=0, select_o=0, valid_o=0, data_o=0.
  - Round-robin pointer ptr=0, hold counter cnt=0.
- States: IDLE, GRANT, TURN.
  - All outputs are registered except data_o.
- data_o is combinational: valid_o ? data[select_o] : 0.
- IDLE:
  - If req_i==0, stay in IDLE.
  - Otherwise pick the first set bit searching ptr, ptr+1, ... modulo 4.
  - Next edge: state=GRANT, select_o=winner, grant_o=1<<winner, valid_o=1, cnt=0.
  - Latency from request sampled to grant visible is 1 cycle.
- GRANT, evaluated each edge with s=select_o:
  - Release if req_i[s]==0.
  - Release if cnt==MAX_HOLD-1 and any other req_i bit is set (preemption).
  - If cnt==MAX_HOLD-1 and no other request is pending: stay granted and keep cnt saturated at MAX_HOLD-1.
  - Otherwise stay and set cnt=cnt+1.
  - On release: state=TURN, grant_o=0, valid_o=0, ptr=s+1 (mod 4, 2-bit wrap 3->0), cnt=0. select_o keeps its value.
- TURN:
  - Exactly one dead cycle with grant_o=0, guaranteeing no overlap between tenures.
  - Next edge: go to IDLE.
  - Arbitration happens in IDLE, so the handover gap is 2 cycles with no grant: the TURN cycle plus the IDLE cycle.
- Simultaneous requests: resolved by rotating priority from ptr only. No fixed priority exists after the first grant.
- A request asserted during GRANT or TURN is not lost if held. Requesters must hold req_i until granted.
- A requester dropping its request while granted is released at the next edge. valid_o stays high for that one edge.
- Invariants:
  - grant_o is always zero or one-hot.
  - valid_o == |grant_o.
  - When valid_o=1, grant_o[select_o]=1.
- MAX_HOLD=1: every tenure is one cycle when others are waiting.
- cnt width is 8 bits.

Test Plan:
- Reset: assert reset_i mid-GRANT with req_i=4'b0100 -> grant_o=0, valid_o=0, data_o=0 immediately. After release, first grant goes to requester 2, because ptr=0 and the search runs 0,1,2.
- Single requester: data1_i=16'h00A0, req_i=4'b0010 at cycle 0 -> cycle 1: grant_o=4'b0010, select_o=1, data_o=16'h00A0. Drop req at cycle 5 -> grant_o=0 at cycle 6.
- Round-robin: data0..3=16'h000A/16'h00A0/16'h0A00/16'hA000, req_i=4'b1111 held, MAX_HOLD=8.
  - Grants in order 0,1,2,3,0, each 8 cycles long, separated by 2 no-grant cycles.
  - data_o matches 16'h000A, 16'h00A0, 16'h0A00, 16'hA000 in turn.
- Hold saturation: only req_i[3] high for 20 cycles -> continuous grant, no preemption. Raise req_i[0] -> released at the next edge, since cnt is saturated. Requester 0 is granted 2 cycles later.
- Wrap: after requester 3 releases, req_i=4'b1001 -> requester 0 granted (ptr wrapped to 0), not requester 3.
- Invariant check every cycle of a 2000-cycle random req_i run:
  - grant_o is one-hot or zero.
  - valid_o == |grant_o.
  - No requester waits more than 3*(MAX_HOLD+2) cycles once it holds its request.
